// File: rtl/serv_dbus_ctrl_if.sv
// Wishbone data-bus bundle between serv_dbus_ctrl (master) and the memory side (slave).
// The err signal exists only when SERV_DBUS_ERR_EN is defined.
interface serv_dbus_ctrl_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
`ifdef SERV_DBUS_ERR_EN
  logic        err;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack, err);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack, err);
`else
  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
`endif
endinterface

// File: rtl/serv_dbus_ctrl.sv
// SERV data-bus sequencer: gathers serial store data, runs one Wishbone cycle, and
// shifts aligned/extended load data back out. Define SERV_DBUS_ERR_EN for bus-error support.
module serv_dbus_ctrl #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req,
  input  logic         i_we,
  input  logic [2:0]   i_funct3,
  input  logic [31:0]  i_adr,
  input  logic [1:0]   i_lsb,
  input  logic         i_en,
  input  logic         i_cnt_done,
  input  logic [W-1:0] i_rs2,
  output logic [W-1:0] o_rdt,
  output logic         o_busy,
  output logic         o_ack,
  output logic         o_misalign,
`ifdef SERV_DBUS_ERR_EN
  output logic         o_err,
`endif
  serv_dbus_ctrl_if.master wb
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] BUS   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  lsb_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [31:0] wb_adr_q;
  logic [31:0] wb_dat_q;
  logic [3:0]  wb_sel_q;
  logic        wb_we_q;
  logic        wb_cyc_q;
  logic        ack_q;
  logic [31:0] sreg;
  logic        sign_q;
  logic [31:0] fill_nxt;
  logic [31:0] rdt_aligned;
  logic        bus_err;
  logic        bus_ok;
  logic        bus_end;
  logic [5:0]  pos;
  logic        beyond;

  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      2'b00:   lane_sel = 4'b0001 << lsb;
      2'b01:   lane_sel = lsb[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic ext_bit(input logic [1:0] size, input logic uns, input logic [31:0] d);
    if (uns)
      ext_bit = 1'b0;
    else if (size == 2'b00)
      ext_bit = d[7];
    else if (size == 2'b01)
      ext_bit = d[15];
    else
      ext_bit = 1'b0;
  endfunction

  assign o_misalign = i_req & (((i_funct3[1:0] == 2'b01) & i_lsb[0]) |
                               (i_funct3[1] & (|i_lsb)));
  assign o_busy     = (state != IDLE);
  assign o_ack      = ack_q;

  assign wb.adr = wb_adr_q;
  assign wb.dat = wb_dat_q;
  assign wb.sel = wb_sel_q;
  assign wb.we  = wb_we_q;
  assign wb.cyc = wb_cyc_q;

`ifdef SERV_DBUS_ERR_EN
  assign bus_err = wb.err;
`else
  assign bus_err = 1'b0;
`endif
  // An error beats a simultaneous ack
  assign bus_ok  = wb.ack & ~bus_err;
  assign bus_end = wb.ack | bus_err;

  assign fill_nxt    = {i_rs2, sreg[31:W]};
  assign rdt_aligned = wb.rdt >> {lsb_q, 3'b000};

  // Serial load output: bits past the loaded size carry the latched extension bit
  always_comb begin
    o_rdt  = '0;
    pos    = '0;
    beyond = 1'b0;
    if (state == DRAIN && i_en) begin
      for (int i = 0; i < W; i++) begin
        pos    = {1'b0, cnt} + 6'(i);
        beyond = (size_q == 2'b00) ? (|pos[5:3]) :
                 (size_q == 2'b01) ? (|pos[5:4]) : 1'b0;
        o_rdt[i] = beyond ? sign_q : sreg[i];
      end
    end
  end

  // Control path and registered bus outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lsb_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= '0;
      wb_we_q  <= 1'b0;
      wb_cyc_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef SERV_DBUS_ERR_EN
      o_err    <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef SERV_DBUS_ERR_EN
      o_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (i_req && !o_misalign) begin
            lsb_q    <= i_lsb;
            size_q   <= i_funct3[1:0];
            uns_q    <= i_funct3[2];
            we_q     <= i_we;
            cnt      <= '0;
            wb_adr_q <= i_adr;
            wb_sel_q <= lane_sel(i_funct3[1:0], i_lsb);
            wb_we_q  <= i_we;
            if (i_we) begin
              state <= FILL;
            end else begin
              state    <= BUS;
              wb_cyc_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (i_en && i_cnt_done) begin
            wb_dat_q <= lane_data(size_q, fill_nxt);
            wb_cyc_q <= 1'b1;
            state    <= BUS;
          end
        end
        BUS: begin
          if (bus_end) begin
            wb_cyc_q <= 1'b0;
            cnt      <= '0;
            if (bus_ok) begin
              ack_q <= 1'b1;
              state <= we_q ? IDLE : DRAIN;
            end else begin
`ifdef SERV_DBUS_ERR_EN
              o_err <= 1'b1;
`endif
              state <= IDLE;
            end
          end
        end
        default: begin
          if (i_en) begin
            cnt <= cnt + 5'(W);
            if (i_cnt_done)
              state <= IDLE;
          end
        end
      endcase
    end
  end

  // Data path: shift register and extension bit carry no reset
  always_ff @(posedge i_clk) begin
    case (state)
      FILL: begin
        if (i_en)
          sreg <= fill_nxt;
      end
      BUS: begin
        if (bus_ok && !we_q) begin
          sreg   <= rdt_aligned;
          sign_q <= ext_bit(size_q, uns_q, rdt_aligned);
        end
      end
      DRAIN: begin
        if (i_en)
          sreg <= sreg >> W;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serv_dbus_ctrl.sv
// Randomized bench for serv_dbus_ctrl: one W=1 and one W=4 instance on a shared
// stimulus bus, checked against a word-level reference model.
module tb_serv_dbus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] adr;
  logic [1:0]  lsb;
  logic        en;
  logic        done;
  logic [3:0]  rs2;
  logic [31:0] bus_rdt;
  logic        bus_ack;

  logic        rdt1;
  logic [3:0]  rdt4;
  logic [1:0]  busy_v, ack_v, mis_v, cyc_v, we_v;
  logic [1:0][31:0] adr_v, dat_v, rdt_v;
  logic [1:0][3:0]  sel_v;
`ifdef SERV_DBUS_ERR_EN
  logic [1:0]  err_v;
`endif

  int errors = 0;
  int checks = 0;

  serv_dbus_ctrl_if wb1();
  serv_dbus_ctrl_if wb4();

  assign wb1.rdt = bus_rdt;
  assign wb1.ack = bus_ack;
  assign wb4.rdt = bus_rdt;
  assign wb4.ack = bus_ack;
`ifdef SERV_DBUS_ERR_EN
  assign wb1.err = 1'b0;
  assign wb4.err = 1'b0;
`endif

  assign cyc_v[0] = wb1.cyc;
  assign cyc_v[1] = wb4.cyc;
  assign we_v[0]  = wb1.we;
  assign we_v[1]  = wb4.we;
  assign adr_v[0] = wb1.adr;
  assign adr_v[1] = wb4.adr;
  assign dat_v[0] = wb1.dat;
  assign dat_v[1] = wb4.dat;
  assign sel_v[0] = wb1.sel;
  assign sel_v[1] = wb4.sel;
  assign rdt_v[0] = {31'b0, rdt1};
  assign rdt_v[1] = {28'b0, rdt4};

  serv_dbus_ctrl #(.W(1)) u_dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req[0]),
    .i_we       (we),
    .i_funct3   (f3),
    .i_adr      (adr),
    .i_lsb      (lsb),
    .i_en       (en),
    .i_cnt_done (done),
    .i_rs2      (rs2[0]),
    .o_rdt      (rdt1),
    .o_busy     (busy_v[0]),
    .o_ack      (ack_v[0]),
    .o_misalign (mis_v[0]),
`ifdef SERV_DBUS_ERR_EN
    .o_err      (err_v[0]),
`endif
    .wb         (wb1.master)
  );

  serv_dbus_ctrl #(.W(4)) u_dut4 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req[1]),
    .i_we       (we),
    .i_funct3   (f3),
    .i_adr      (adr),
    .i_lsb      (lsb),
    .i_en       (en),
    .i_cnt_done (done),
    .i_rs2      (rs2),
    .o_rdt      (rdt4),
    .o_busy     (busy_v[1]),
    .o_ack      (ack_v[1]),
    .o_misalign (mis_v[1]),
`ifdef SERV_DBUS_ERR_EN
    .o_err      (err_v[1]),
`endif
    .wb         (wb4.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: what the bus and the core should see for a transaction
  function automatic logic [3:0] m_sel(input logic [1:0] size, input logic [1:0] l);
    if (size == 2'd0)      return 4'(1 << l);
    else if (size == 2'd1) return (l >= 2) ? 4'hC : 4'h3;
    else                   return 4'hF;
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] size, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[7:0];
    h = d[15:0];
    if (size == 2'd0)      return {b, b, b, b};
    else if (size == 2'd1) return {h, h};
    else                   return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] fn, input logic [1:0] l, input logic [31:0] r);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = r >> (8 * l);
    b  = sh[7:0];
    h  = sh[15:0];
    if (fn[1:0] == 2'd0)      return fn[2] ? {24'h0, b} : {{24{b[7]}}, b};
    else if (fn[1:0] == 2'd1) return fn[2] ? {16'h0, h} : {{16{h[15]}}, h};
    else                      return sh;
  endfunction

  task automatic txn(input int inst, input logic w, input logic [2:0] fn, input logic [31:0] a,
                     input logic [1:0] l, input logic [31:0] data, input logic [31:0] rd,
                     input int dly);
    int          wi;
    int          beats;
    logic [31:0] res;
    wi    = (inst != 0) ? 4 : 1;
    beats = 32 / wi;
    res   = '0;
    @(negedge clk);
    we = w; f3 = fn; adr = a; lsb = l; req[inst] = 1'b1;
    #1 chk("misalign_low", mis_v[inst], 0);
    @(negedge clk);
    req = '0;
    chk("busy_start", busy_v[inst], 1);
    if (w) begin
      chk("fill_no_cyc", cyc_v[inst], 0);
      for (int b = 0; b < beats; b++) begin
        rs2  = 4'(data >> (b * wi));
        en   = 1'b1;
        done = (b == beats - 1);
        @(negedge clk);
      end
      en = 1'b0; done = 1'b0;
    end
    chk("cyc_rise", cyc_v[inst], 1);
    chk("wb_adr", adr_v[inst], a);
    chk("wb_sel", sel_v[inst], m_sel(fn[1:0], l));
    chk("wb_we", we_v[inst], w);
    if (w) chk("wb_dat", dat_v[inst], m_dat(fn[1:0], data));
    for (int k = 0; k < dly; k++) @(negedge clk);
    chk("cyc_hold", cyc_v[inst], 1);
    bus_ack = 1'b1; bus_rdt = rd;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdt = $urandom;
    chk("cyc_fall", cyc_v[inst], 0);
    chk("ack_pulse", ack_v[inst], 1);
    if (w) begin
      chk("store_idle", busy_v[inst], 0);
    end else begin
      chk("drain_busy", busy_v[inst], 1);
      #1 chk("rdt_gated", rdt_v[inst], 0);
      for (int b = 0; b < beats; b++) begin
        en   = 1'b1;
        done = (b == beats - 1);
        #1 res = res | (rdt_v[inst] << (b * wi));
        @(negedge clk);
      end
      en = 1'b0; done = 1'b0;
      chk("load_data", res, m_load(fn, l, rd));
      chk("load_idle", busy_v[inst], 0);
    end
    @(negedge clk);
    chk("ack_single", ack_v[inst], 0);
  endtask

  task automatic mis(input int inst, input logic [2:0] fn, input logic [1:0] l);
    @(negedge clk);
    we = 1'($urandom); f3 = fn; lsb = l; adr = 32'h0000_0500; req[inst] = 1'b1;
    #1 chk("misalign_high", mis_v[inst], 1);
    @(negedge clk);
    req = '0;
    chk("mis_idle", busy_v[inst], 0);
    chk("mis_no_cyc", cyc_v[inst], 0);
  endtask

  initial begin
    logic [1:0]  size;
    logic [1:0]  l;
    logic [31:0] rnd;
    int          inst;
    rst_n = 1'b0; req = '0; we = 1'b0; f3 = '0; adr = '0; lsb = '0;
    en = 1'b0; done = 1'b0; rs2 = '0; bus_rdt = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy_v[i], 0);
      chk("rst_cyc", cyc_v[i], 0);
      chk("rst_ack", ack_v[i], 0);
      chk("rst_adr", adr_v[i], 0);
      chk("rst_sel", sel_v[i], 0);
      chk("rst_dat", dat_v[i], 0);
      chk("rst_we", we_v[i], 0);
      chk("rst_rdt", rdt_v[i], 0);
    end
    rst_n = 1'b1;

    txn(0, 1'b1, 3'b010, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF, 32'h0, 1);
    txn(0, 1'b1, 3'b000, 32'h0000_0200, 2'd2, 32'h0000_00A5, 32'h0, 0);
    txn(0, 1'b0, 3'b000, 32'h0000_0300, 2'd3, 32'h0, 32'h8011_2233, 2);
    txn(0, 1'b0, 3'b101, 32'h0000_0304, 2'd2, 32'h0, 32'hBEEF_1234, 0);
    mis(0, 3'b001, 2'd1);

    // Reset in the middle of a bus cycle, with the ack arriving late
    @(negedge clk);
    we = 1'b0; f3 = 3'b010; adr = 32'h0000_0600; lsb = 2'd0; req[0] = 1'b1;
    @(negedge clk);
    req = '0;
    chk("rst_mid_cyc", cyc_v[0], 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_async_cyc", cyc_v[0], 0);
    chk("rst_async_adr", adr_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdt = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_ignored", ack_v[0], 0);
    chk("late_ack_cyc", cyc_v[0], 0);
    chk("late_ack_idle", busy_v[0], 0);
    txn(0, 1'b0, 3'b010, 32'h0000_0604, 2'd0, 32'h0, 32'hCAFE_F00D, 1);

    txn(1, 1'b0, 3'b010, 32'h0000_0400, 2'd0, 32'h0, 32'h1234_5678, 1);

    for (int n = 0; n < 60; n++) begin
      inst = int'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 2));
      l    = 2'($urandom);
      rnd  = $urandom;
      if ((size == 2'd1 && l[0]) || (size == 2'd2 && l != 2'd0))
        mis(inst, {rnd[0], size}, l);
      else
        txn(inst, rnd[1], {rnd[0], size}, {rnd[31:2], 2'b00}, l, $urandom, $urandom,
            int'($urandom_range(0, 3)));
    end

`ifdef SERV_DBUS_ERR_EN
    chk("no_err0", err_v[0], 0);
    chk("no_err1", err_v[1], 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
